// File: rtl/ttt_pkg.sv
// ==========================================================================
// ttt_pkg : shared board constants, filter FSM states and one-hot helpers
// Revision: 1.0
// ==========================================================================
`default_nettype none

package ttt_pkg;

  localparam int NUM_SQUARES = 9;
  localparam int IDX_W       = 4;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    QUALIFY      = 3'd1,
    CHECK        = 3'd2,
    OFFER        = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_e;

  function automatic logic is_onehot(input logic [NUM_SQUARES-1:0] v);
    return (v != '0) && ((v & (v - NUM_SQUARES'(1))) == '0);
  endfunction

  // Only meaningful for a one-hot input; the highest set bit wins otherwise.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_SQUARES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SQUARES; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ==========================================================================
// sync_2ff : two-flop synchronizer for a bus of independent async bits
// Revision: 1.0
// ==========================================================================
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/click_move_filter.sv
// ==========================================================================
// click_move_filter : turns a held mouse click into one qualified board move
// Revision: 1.0
// ==========================================================================
`default_nettype none

module click_move_filter
  import ttt_pkg::*;
#(
  parameter int HOLD_CYCLES     = 1000000,
  parameter int COOLDOWN_CYCLES = 5000000
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_n,
  input  logic [NUM_SQUARES-1:0] clickedMatrix,
  input  logic [NUM_SQUARES-1:0] occupied,
  input  logic                   enable,
  input  logic                   move_ready,
  output logic                   move_valid,
  output logic [NUM_SQUARES-1:0] move_square,
  output logic [IDX_W-1:0]       move_index,
  output logic                   reject_pulse
);

  localparam int MAX_CYC = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);

  logic [NUM_SQUARES-1:0] sclk;
  logic                   legal;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_SQUARES-1:0] sample_q;
  logic                   valid_q;
  logic [NUM_SQUARES-1:0] square_q;
  logic [IDX_W-1:0]       index_q;
  logic                   reject_q;

  sync_2ff #(
    .WIDTH (NUM_SQUARES)
  ) u_sync (
    .clk_i  (clk_100MHz),
    .rst_ni (reset_n),
    .d_i    (clickedMatrix),
    .q_o    (sclk)
  );

  assign legal = is_onehot(sample_q) && ((sample_q & occupied) == '0);

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      square_q <= '0;
      index_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((sclk != '0) && enable) begin
            sample_q <= sclk;
            cnt_q    <= '0;
            state_q  <= QUALIFY;
          end
        end

        QUALIFY: begin
          if ((sclk != sample_q) || !enable) begin
            state_q <= IDLE;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        CHECK: begin
          if (!legal) begin
            reject_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WAIT_RELEASE;
          end else begin
            valid_q  <= 1'b1;
            square_q <= sample_q;
            index_q  <= onehot_to_idx(sample_q);
            state_q  <= OFFER;
          end
        end

        // A completed handshake takes precedence over an abort in the same cycle.
        OFFER: begin
          if (move_ready) begin
            valid_q  <= 1'b0;
            square_q <= '0;
            index_q  <= '0;
            cnt_q    <= '0;
            state_q  <= WAIT_RELEASE;
          end else if (!enable) begin
            valid_q  <= 1'b0;
            square_q <= '0;
            index_q  <= '0;
            state_q  <= IDLE;
          end
        end

        WAIT_RELEASE: begin
          if (sclk != '0) begin
            cnt_q <= '0;
          end else if (cnt_q == COOL_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign move_valid   = valid_q;
  assign move_square  = square_q;
  assign move_index   = index_q;
  assign reject_pulse = reject_q;

endmodule

`default_nettype wire

// File: tb/tb_click_move_filter.sv
// ==========================================================================
// tb_click_move_filter : directed self-checking bench, HOLD=4, COOLDOWN=3
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_click_move_filter;

  localparam int HOLD = 4;
  localparam int COOL = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] clickedMatrix;
  logic [8:0] occupied;
  logic       enable;
  logic       move_ready;
  logic       move_valid;
  logic [8:0] move_square;
  logic [3:0] move_index;
  logic       reject_pulse;

  int n_total = 0;
  int n_bad   = 0;
  int xfers   = 0;
  int rejects = 0;
  int viol    = 0;

  always #5 clk = ~clk;

  click_move_filter #(
    .HOLD_CYCLES     (HOLD),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clk_100MHz    (clk),
    .reset_n       (reset_n),
    .clickedMatrix (clickedMatrix),
    .occupied      (occupied),
    .enable        (enable),
    .move_ready    (move_ready),
    .move_valid    (move_valid),
    .move_square   (move_square),
    .move_index    (move_index),
    .reject_pulse  (reject_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after posedge, so mid-cycle values are stable.
  always @(negedge clk) begin
    if (reset_n) begin
      if (move_valid && move_ready) xfers++;
      if (reject_pulse) rejects++;
      if (move_valid && reject_pulse) viol++;
      if (!move_valid && ((move_square != 9'd0) || (move_index != 4'd0))) viol++;
      if (move_valid && (move_square != (9'd1 << move_index))) viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k = posedges after the drive until valid; the first one captures the input.
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!move_valid && (k < 40));
  endtask

  task automatic release_click();
    clickedMatrix = 9'd0;
    repeat (10) step();
  endtask

  int k;
  int x0;
  int r0;
  int stab;

  initial begin
    reset_n       = 1'b1;
    clickedMatrix = 9'd0;
    occupied      = 9'd0;
    enable        = 1'b0;
    move_ready    = 1'b0;
    #1 reset_n    = 1'b0;
    #2;
    chk("rst_valid",  32'(move_valid),   32'd0);
    chk("rst_square", 32'(move_square),  32'd0);
    chk("rst_index",  32'(move_index),   32'd0);
    chk("rst_reject", 32'(reject_pulse), 32'd0);
    repeat (3) step();
    reset_n    = 1'b1;
    enable     = 1'b1;
    move_ready = 1'b1;
    step();

    // Centre square, legal, ready high: one-cycle offer.
    x0 = xfers;
    clickedMatrix = 9'h010;
    wait_valid(k);
    chk("t1_latency", 32'(k - 1), 32'd7);
    chk("t1_index",   32'(move_index),  32'd4);
    chk("t1_square",  32'(move_square), 32'h010);
    step();
    chk("t1_drop",    32'(move_valid), 32'd0);
    chk("t1_xfer",    32'(xfers - x0), 32'd1);
    repeat (20) step();
    chk("t1_one_per_press", 32'(xfers - x0), 32'd1);
    release_click();

    // Occupied square.
    x0 = xfers; r0 = rejects;
    occupied      = 9'h001;
    clickedMatrix = 9'h001;
    repeat (15) step();
    release_click();
    chk("t2_reject", 32'(rejects - r0), 32'd1);
    chk("t2_nomove", 32'(xfers - x0),   32'd0);
    occupied = 9'd0;

    // Multi-hot click.
    x0 = xfers; r0 = rejects;
    clickedMatrix = 9'h003;
    repeat (15) step();
    release_click();
    chk("t3_reject", 32'(rejects - r0), 32'd1);
    chk("t3_nomove", 32'(xfers - x0),   32'd0);

    // Backpressure: offer must hold steady until ready.
    x0 = xfers;
    move_ready    = 1'b0;
    clickedMatrix = 9'h100;
    wait_valid(k);
    chk("t4_valid", 32'(move_valid), 32'd1);
    stab = 0;
    repeat (10) begin
      step();
      if (!move_valid || (move_index != 4'd8) || (move_square != 9'h100)) stab++;
    end
    chk("t4_stable", 32'(stab),        32'd0);
    chk("t4_noxfer", 32'(xfers - x0),  32'd0);
    move_ready = 1'b1;
    step();
    chk("t4_drop",   32'(move_valid),  32'd0);
    chk("t4_xfer",   32'(xfers - x0),  32'd1);
    release_click();

    // Short glitchy presses, then a long stable one.
    x0 = xfers; r0 = rejects;
    clickedMatrix = 9'h020; repeat (3) step();
    clickedMatrix = 9'h000; step();
    clickedMatrix = 9'h020; repeat (3) step();
    clickedMatrix = 9'h000; repeat (10) step();
    chk("t5_glitch_move", 32'(xfers - x0),   32'd0);
    chk("t5_glitch_rej",  32'(rejects - r0), 32'd0);
    clickedMatrix = 9'h020;
    repeat (50) step();
    release_click();
    chk("t5_held", 32'(xfers - x0), 32'd1);

    // Enable drop aborts a pending offer.
    x0 = xfers;
    move_ready    = 1'b0;
    clickedMatrix = 9'h004;
    wait_valid(k);
    chk("t6_offer", 32'(move_valid), 32'd1);
    enable = 1'b0;
    step();
    chk("t6_abort", 32'(move_valid), 32'd0);
    clickedMatrix = 9'd0;
    repeat (5) step();
    enable     = 1'b1;
    move_ready = 1'b1;
    repeat (5) step();
    chk("t6_noxfer", 32'(xfers - x0), 32'd0);

    // Reset mid-offer drops valid asynchronously; next press needs full qualify.
    x0 = xfers;
    move_ready    = 1'b0;
    clickedMatrix = 9'h002;
    wait_valid(k);
    chk("t7_offer", 32'(move_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_async_drop", 32'(move_valid), 32'd0);
    clickedMatrix = 9'd0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    move_ready = 1'b1;
    chk("t7_discard", 32'(xfers - x0), 32'd0);
    clickedMatrix = 9'h002;
    wait_valid(k);
    chk("t7_latency", 32'(k - 1),       32'd7);
    chk("t7_index",   32'(move_index),  32'd1);
    step();
    release_click();
    chk("t7_xfer", 32'(xfers - x0), 32'd1);

    chk("invariants", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
